// File: rtl/ripple_count_capture.sv
// Capture stage for an asynchronous ripple counter: two-flop resync, stability filter, clean count.
// Optional saturating wrap counter is built only when RIPPLE_CAPTURE_WRAP_COUNT_EN is defined.
module ripple_count_capture #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr,
  output logic [WIDTH-1:0] count_out,
  output logic             count_valid,
  output logic             wrap,
  output logic             terminal,
  output logic             primed,
  output logic [7:0]       wraps
);

  typedef enum logic [1:0] {FLUSH, ACQUIRE, HOLD, SETTLE} state_t;

  localparam int             SW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]  STAB_ONE  = SW'(1);
  localparam logic [SW-1:0]  STAB_LAST = SW'(STABLE_CYCLES - 1);

  state_t           state_q;
  logic             flush_q;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q;
  logic [SW-1:0]    stab_q;
  logic [WIDTH-1:0] count_q;
  logic             valid_q, wrap_q, primed_q;

  logic             cand_match, stab_done, settle_accept, wrap_d;

  always_comb begin
    cand_match    = (sync2_q == cand_q);
    stab_done     = (stab_q == STAB_LAST);
    settle_accept = (state_q == SETTLE) && cand_match && stab_done && (cand_q != count_q);
    wrap_d        = settle_accept && (cand_q < count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= FLUSH;
      flush_q  <= 1'b0;
      cand_q   <= '0;
      stab_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync1_q <= cnt_in;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      case (state_q)
        FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            flush_q <= 1'b0;
            state_q <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          // stab==0 marks the first acquisition edge after the flush
          if (stab_q == '0 || !cand_match) begin
            cand_q <= sync2_q;
            stab_q <= STAB_ONE;
          end else if (stab_done) begin
            count_q  <= cand_q;
            valid_q  <= 1'b1;
            primed_q <= 1'b1;
            state_q  <= HOLD;
          end else begin
            stab_q <= stab_q + STAB_ONE;
          end
        end
        HOLD: begin
          if (sync2_q != count_q) begin
            cand_q  <= sync2_q;
            stab_q  <= STAB_ONE;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (!cand_match) begin
            cand_q <= sync2_q;
            stab_q <= STAB_ONE;
          end else if (stab_done) begin
            if (settle_accept) begin
              count_q <= cand_q;
              valid_q <= 1'b1;
              wrap_q  <= wrap_d;
            end
            state_q <= HOLD;
          end else begin
            stab_q <= stab_q + STAB_ONE;
          end
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign wrap        = wrap_q;
  assign primed      = primed_q;
  assign terminal    = primed_q && (&count_q);

`ifdef RIPPLE_CAPTURE_WRAP_COUNT_EN
  logic [7:0] wraps_q;

  // Counter steps on the same edge that raises wrap; clr takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wraps_q <= 8'd0;
    end else if (clr) begin
      wraps_q <= 8'd0;
    end else if (wrap_d && (wraps_q != 8'hFF)) begin
      wraps_q <= wraps_q + 8'd1;
    end
  end

  assign wraps = wraps_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign wraps      = 8'd0;
`endif

endmodule
